// File: rtl/stream_mux_arb_pkg.sv
// Shared types and helpers for the N-to-1 stream multiplexer/arbiter.
package stream_mux_arb_pkg;

  // Top-level packet FSM: IDLE arbitrates every beat, LOCKED follows one channel.
  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // Width of a channel index; never less than one bit so a 1-channel build stays legal.
  function automatic int ch_width(input int n);
    if (n <= 1) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/stream_mux_arb_if.sv
// Bundles the multi-channel input streams, the single output stream and the
// busy flag. The mux sits on the slave side; the producers and sink on the master side.
interface stream_mux_arb_if
  import stream_mux_arb_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8
);

  localparam int CH_W = ch_width(NUM_CH);

  logic [NUM_CH*DATA_W-1:0] in_data;
  logic [NUM_CH-1:0]        in_valid;
  logic [NUM_CH-1:0]        in_last;
  logic [NUM_CH-1:0]        in_ready;
  logic [DATA_W-1:0]        out_data;
  logic                     out_valid;
  logic                     out_last;
  logic [CH_W-1:0]          out_ch;
  logic                     out_ready;
  logic                     busy;

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_valid, out_last, out_ch, busy
  );

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_valid, out_last, out_ch, busy
  );

endinterface

// File: rtl/stream_mux_arb_rr_arbiter.sv
// Purely combinational request arbiter. In round-robin mode the search starts
// at ptr and wraps; in fixed-priority mode the lowest requesting index wins.
module rr_arbiter #(
  parameter int NUM_CH  = 4,
  parameter int MODE_RR = 1,
  parameter int CH_W    = 2
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   ptr,
  output logic [NUM_CH-1:0] gnt,
  output logic [CH_W-1:0]   gnt_idx,
  output logic              gnt_vld
);

  logic [NUM_CH-1:0] gnt_s;
  logic [CH_W-1:0]   idx_s;
  logic              found_s;

  // Walk the candidates in priority order and keep the first requester.
  always_comb begin
    int            sum_v;
    logic [CH_W-1:0] cand_v;
    gnt_s   = {NUM_CH{1'b0}};
    idx_s   = {CH_W{1'b0}};
    found_s = 1'b0;
    sum_v   = 0;
    cand_v  = {CH_W{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      if (MODE_RR != 0) begin
        sum_v = int'(ptr) + i;
        if (sum_v >= NUM_CH) begin
          sum_v = sum_v - NUM_CH;
        end else begin
          sum_v = sum_v;
        end
      end else begin
        sum_v = i;
      end
      cand_v = CH_W'(sum_v);
      if (!found_s && req[cand_v]) begin
        found_s       = 1'b1;
        gnt_s[cand_v] = 1'b1;
        idx_s         = cand_v;
      end else begin
        found_s = found_s;
      end
    end
  end

  assign gnt     = gnt_s;
  assign gnt_idx = idx_s;
  assign gnt_vld = found_s;

endmodule

// File: rtl/stream_mux_arb.sv
// N-to-1 stream multiplexer with internal arbitration, optional packet lock
// (released by an accepted in_last beat) and a registered output stage.
module stream_mux_arb
  import stream_mux_arb_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int DATA_W       = 8,
  parameter int MODE_RR      = 1,
  parameter int LOCK_ON_LAST = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  stream_mux_arb_if.slave   bus
);

  localparam int              CH_W    = ch_width(NUM_CH);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  // FSM and arbitration state
  state_t          state_q, state_d;
  logic [CH_W-1:0] lock_ch_q, lock_ch_d;
  logic [CH_W-1:0] ptr_q, ptr_d;

  // Output register
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic [CH_W-1:0]   out_ch_q, out_ch_d;

  // Combinational helpers
  logic [NUM_CH-1:0] arb_gnt_s;
  logic [CH_W-1:0]   arb_idx_s;
  logic              arb_vld_s;
  logic [CH_W-1:0]   grant_idx_s;
  logic              load_en_s;
  logic [NUM_CH-1:0] in_ready_s;
  logic              accept_s;
  logic [DATA_W-1:0] acc_data_s;
  logic              acc_last_s;
  logic              busy_s;

  rr_arbiter #(
    .NUM_CH  (NUM_CH),
    .MODE_RR (MODE_RR),
    .CH_W    (CH_W)
  ) u_arb (
    .req     (bus.in_valid),
    .ptr     (ptr_q),
    .gnt     (arb_gnt_s),
    .gnt_idx (arb_idx_s),
    .gnt_vld (arb_vld_s)
  );

  // The output register can take a new beat when empty or being drained.
  assign load_en_s = !out_valid_q || bus.out_ready;

  // A locked packet overrides the arbiter so other channels cannot interleave.
  always_comb begin
    grant_idx_s = arb_idx_s;
    if (state_q == LOCKED) begin
      grant_idx_s = lock_ch_q;
    end else begin
      grant_idx_s = arb_idx_s;
    end
  end

  // Select payload and last flag of the granted channel.
  always_comb begin
    acc_data_s = {DATA_W{1'b0}};
    acc_last_s = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant_idx_s == CH_W'(i)) begin
        acc_data_s = bus.in_data[i*DATA_W +: DATA_W];
        acc_last_s = bus.in_last[i];
      end else begin
        acc_data_s = acc_data_s;
      end
    end
  end

  assign accept_s = |(bus.in_valid & in_ready_s);

  // FSM state register together with the lock channel and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      lock_ch_q <= {CH_W{1'b0}};
      ptr_q     <= {CH_W{1'b0}};
    end else begin
      state_q   <= state_d;
      lock_ch_q <= lock_ch_d;
      ptr_q     <= ptr_d;
    end
  end

  // FSM next state: lock on a non-last beat, release on an accepted last beat.
  always_comb begin
    state_d   = state_q;
    lock_ch_d = lock_ch_q;
    case (state_q)
      IDLE: begin
        if (accept_s && (LOCK_ON_LAST != 0) && !acc_last_s) begin
          state_d   = LOCKED;
          lock_ch_d = grant_idx_s;
        end else begin
          state_d   = IDLE;
        end
      end
      LOCKED: begin
        if (accept_s && acc_last_s) begin
          state_d = IDLE;
        end else begin
          state_d = LOCKED;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Pointer moves just past the channel served so it gets lowest priority next.
  always_comb begin
    ptr_d = ptr_q;
    if (accept_s) begin
      if (grant_idx_s == LAST_CH) begin
        ptr_d = {CH_W{1'b0}};
      end else begin
        ptr_d = grant_idx_s + CH_W'(1);
      end
    end else begin
      ptr_d = ptr_q;
    end
  end

  // FSM outputs: ready decode (gated by reset and output space) and busy flag.
  always_comb begin
    in_ready_s = {NUM_CH{1'b0}};
    busy_s     = (state_q == LOCKED);
    if (!rst_n || !load_en_s) begin
      in_ready_s = {NUM_CH{1'b0}};
    end else if (state_q == LOCKED) begin
      in_ready_s[lock_ch_q] = 1'b1;
    end else if (arb_vld_s) begin
      in_ready_s = arb_gnt_s;
    end else begin
      in_ready_s = {NUM_CH{1'b0}};
    end
  end

  // Output stage next value: load on space, otherwise hold for the sink.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_ch_d    = out_ch_q;
    if (load_en_s) begin
      out_valid_d = accept_s;
      if (accept_s) begin
        out_data_d = acc_data_s;
        out_last_d = acc_last_s;
        out_ch_d   = grant_idx_s;
      end else begin
        out_data_d = out_data_q;
      end
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= {DATA_W{1'b0}};
      out_last_q  <= 1'b0;
      out_ch_q    <= {CH_W{1'b0}};
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_ch_q    <= out_ch_d;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.busy      = busy_s;

endmodule

// File: tb/tb_stream_mux_arb.sv
// Directed bench: one round-robin/packet-lock instance and one fixed-priority
// pass-through instance, driven with hand-computed expectations.
module tb_stream_mux_arb;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  stream_mux_arb_if #(.NUM_CH(4), .DATA_W(8)) rr_if ();
  stream_mux_arb_if #(.NUM_CH(4), .DATA_W(8)) fp_if ();

  stream_mux_arb #(.NUM_CH(4), .DATA_W(8), .MODE_RR(1), .LOCK_ON_LAST(1)) dut_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (rr_if)
  );

  stream_mux_arb #(.NUM_CH(4), .DATA_W(8), .MODE_RR(0), .LOCK_ON_LAST(0)) dut_fp (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (fp_if)
  );

  task automatic check(input string tag, input logic [31:0] obs_v, input logic [31:0] exp_v);
    n_tests++;
    if (obs_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs_v, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic rr_ch(input int ch, input logic v, input logic [7:0] d, input logic l);
    rr_if.in_valid[ch]       = v;
    rr_if.in_data[ch*8 +: 8] = d;
    rr_if.in_last[ch]        = l;
  endtask

  task automatic rr_out(input string tag, input logic [7:0] d, input logic [1:0] ch,
                        input logic l, input logic b);
    check({tag, "/valid"}, 32'(rr_if.out_valid), 32'd1);
    check({tag, "/data"},  32'(rr_if.out_data),  32'(d));
    check({tag, "/ch"},    32'(rr_if.out_ch),    32'(ch));
    check({tag, "/last"},  32'(rr_if.out_last),  32'(l));
    check({tag, "/busy"},  32'(rr_if.busy),      32'(b));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    rr_if.out_ready = 1'b1;
    fp_if.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rr_ch(i, 1'b1, 8'(8'hA0 + i), 1'b1);
    end
    fp_if.in_valid = 4'b1010;
    fp_if.in_data  = {8'hB3, 8'hB2, 8'hB1, 8'hB0};
    fp_if.in_last  = 4'b1000;

    // Reset with valids high
    repeat (3) step();
    check("rst/in_ready",  32'(rr_if.in_ready),  32'd0);
    check("rst/out_valid", 32'(rr_if.out_valid), 32'd0);
    check("rst/out_data",  32'(rr_if.out_data),  32'd0);
    check("rst/out_last",  32'(rr_if.out_last),  32'd0);
    check("rst/out_ch",    32'(rr_if.out_ch),    32'd0);
    check("rst/busy",      32'(rr_if.busy),      32'd0);
    check("rst/fp_ready",  32'(fp_if.in_ready),  32'd0);
    check("rst/fp_valid",  32'(fp_if.out_valid), 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel/rr_ready", 32'(rr_if.in_ready), 32'h1);
    check("rel/fp_ready", 32'(fp_if.in_ready), 32'h2);

    // Round-robin fairness and fixed priority side by side
    for (int k = 0; k < 6; k++) begin
      step();
      rr_out($sformatf("rr%0d", k), 8'(8'hA0 + (k % 4)), 2'(k % 4), 1'b1, 1'b0);
      check($sformatf("rr%0d/in_ready", k), 32'(rr_if.in_ready), 32'(1 << ((k + 1) % 4)));
      check($sformatf("fp%0d/ch", k),       32'(fp_if.out_ch),    32'd1);
      check($sformatf("fp%0d/data", k),     32'(fp_if.out_data),  32'hB1);
      check($sformatf("fp%0d/last", k),     32'(fp_if.out_last),  32'd0);
      check($sformatf("fp%0d/busy", k),     32'(fp_if.busy),      32'd0);
      check($sformatf("fp%0d/in_ready", k), 32'(fp_if.in_ready),  32'h2);
    end

    // No requests: output drains
    rr_if.in_valid = 4'b0000;
    step();
    check("idle/out_valid", 32'(rr_if.out_valid), 32'd0);
    check("idle/in_ready",  32'(rr_if.in_ready),  32'd0);

    // Packet lock on ch2 while ch0/ch1 compete (ptr is 2 here)
    rr_ch(0, 1'b1, 8'h50, 1'b1);
    rr_ch(1, 1'b1, 8'h60, 1'b1);
    rr_ch(2, 1'b1, 8'h11, 1'b0);
    rr_ch(3, 1'b0, 8'h00, 1'b0);
    #1;
    check("pkt/in_ready0", 32'(rr_if.in_ready), 32'h4);
    check("pkt/busy0",     32'(rr_if.busy),     32'd0);
    step();
    rr_out("pktA", 8'h11, 2'd2, 1'b0, 1'b1);
    check("pktA/in_ready", 32'(rr_if.in_ready), 32'h4);
    rr_ch(2, 1'b1, 8'h22, 1'b0);
    step();
    rr_out("pktB", 8'h22, 2'd2, 1'b0, 1'b1);
    rr_ch(2, 1'b1, 8'h33, 1'b1);
    step();
    rr_out("pktC", 8'h33, 2'd2, 1'b1, 1'b0);
    rr_ch(2, 1'b0, 8'h00, 1'b0);
    #1;
    check("post_lock/in_ready", 32'(rr_if.in_ready), 32'h1);
    step();
    rr_out("after", 8'h50, 2'd0, 1'b1, 1'b0);

    // Locked channel goes idle: nobody else is served
    rr_ch(1, 1'b1, 8'h44, 1'b0);
    #1;
    check("pktD/in_ready", 32'(rr_if.in_ready), 32'h2);
    step();
    rr_out("pktD", 8'h44, 2'd1, 1'b0, 1'b1);
    rr_ch(1, 1'b0, 8'h00, 1'b0);
    rr_ch(3, 1'b1, 8'h99, 1'b1);
    for (int k = 0; k < 2; k++) begin
      step();
      check($sformatf("wait%0d/out_valid", k), 32'(rr_if.out_valid), 32'd0);
      check($sformatf("wait%0d/busy", k),      32'(rr_if.busy),      32'd1);
      check($sformatf("wait%0d/others", k),    32'(rr_if.in_ready & 4'b1101), 32'd0);
    end

    // Backpressure mid-packet
    rr_ch(1, 1'b1, 8'h55, 1'b0);
    #1;
    check("pktE/in_ready", 32'(rr_if.in_ready), 32'h2);
    step();
    rr_out("pktE", 8'h55, 2'd1, 1'b0, 1'b1);
    rr_if.out_ready = 1'b0;
    rr_ch(1, 1'b1, 8'h66, 1'b0);
    #1;
    check("bp/in_ready0", 32'(rr_if.in_ready), 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      rr_out($sformatf("bp%0d", k), 8'h55, 2'd1, 1'b0, 1'b1);
      check($sformatf("bp%0d/in_ready", k), 32'(rr_if.in_ready), 32'd0);
    end
    rr_if.out_ready = 1'b1;
    #1;
    check("bp/in_ready_rel", 32'(rr_if.in_ready), 32'h2);
    step();
    rr_out("pktF", 8'h66, 2'd1, 1'b0, 1'b1);

    // Reset while locked
    #1;
    rst_n = 1'b0;
    #1;
    check("mrst/out_valid", 32'(rr_if.out_valid), 32'd0);
    check("mrst/busy",      32'(rr_if.busy),      32'd0);
    check("mrst/in_ready",  32'(rr_if.in_ready),  32'd0);
    check("mrst/out_data",  32'(rr_if.out_data),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rr_ch(0, 1'b1, 8'h77, 1'b1);
    #1;
    check("mrst/in_ready_rel", 32'(rr_if.in_ready), 32'h1);
    check("mrst/busy_rel",     32'(rr_if.busy),     32'd0);
    step();
    rr_out("post_rst", 8'h77, 2'd0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
